led_pattern_pwm: RTL and testbench

- Drives the board's 8 user LEDs with animated, brightness-controlled patterns: off, scanner with fading tail, breathing, and binary count.
- Sits directly downstream of the free-running-counter LED logic and replaces the constant led[7:0] assignment.
- Contains its own step prescaler and an 8-bit PWM engine; led[7:0] connects straight to the pins.

---
 rtl/led_pattern_pwm.sv | 155 +++++++++++++++
 tb/tb_led_pattern_pwm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_pwm.sv
// rtl/led_pattern_pwm.sv - animated LED patterns (off/scan/breathe/count) through an 8-bit PWM engine
module led_pattern_pwm #(
   parameter int STEP_DIV    = 1000000,
   parameter int BREATHE_INC = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] mode,
   output logic [7:0] led,
   output logic       step_pulse
);

   localparam int            CW        = $clog2(STEP_DIV);
   localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 1);
   localparam logic [8:0]    INC9      = 9'(BREATHE_INC);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [CW-1:0]   step_cnt_q, step_cnt_d;
   logic [1:0]      cur_mode_q, cur_mode_d;
   logic [2:0]      pos_q, pos_d;
   dir_e            dir_q, dir_d;
   logic [7:0]      level_q, level_d;
   logic [7:0]      count_q, count_d;
   logic [7:0][7:0] duty_q, duty_d;
   logic [7:0]      led_q, led_d;
   logic            step_pulse_q, step_pulse_d;

   logic            step_tick;
   logic [2:0]      pos_nxt;
   logic [8:0]      lvl9;

   assign step_tick = enable && (step_cnt_q == STEP_LAST);

   always_comb begin
      pwm_cnt_d    = pwm_cnt_q;
      step_cnt_d   = step_cnt_q;
      cur_mode_d   = cur_mode_q;
      pos_d        = pos_q;
      dir_d        = dir_q;
      level_d      = level_q;
      count_d      = count_q;
      duty_d       = duty_q;
      led_d        = '0;
      step_pulse_d = step_tick;
      pos_nxt      = pos_q;
      lvl9         = {1'b0, level_q};

      if (enable) begin
         pwm_cnt_d  = pwm_cnt_q + 8'd1;
         step_cnt_d = step_tick ? '0 : step_cnt_q + CW'(1);
         for (int i = 0; i < 8; i++) begin
            led_d[i] = (duty_q[i] > pwm_cnt_q);
         end
      end

      if (step_tick) begin
         if (mode != cur_mode_q) begin
            // A mode change only re-arms the pattern; its first advance comes on the next tick.
            cur_mode_d = mode;
            pos_d      = 3'd0;
            dir_d      = DIR_UP;
            level_d    = 8'd0;
            count_d    = 8'd0;
            duty_d     = '0;
         end else begin
            case (cur_mode_q)
               2'd0: duty_d = '0;
               2'd1: begin
                  if (dir_q == DIR_UP) begin
                     if (pos_q == 3'd7) begin
                        pos_nxt = 3'd6;
                        dir_d   = DIR_DOWN;
                     end else begin
                        pos_nxt = pos_q + 3'd1;
                     end
                  end else begin
                     if (pos_q == 3'd0) begin
                        pos_nxt = 3'd1;
                        dir_d   = DIR_UP;
                     end else begin
                        pos_nxt = pos_q - 3'd1;
                     end
                  end
                  pos_d = pos_nxt;
                  for (int i = 0; i < 8; i++) begin
                     duty_d[i] = duty_q[i] >> 1;
                  end
                  duty_d[pos_nxt] = 8'hFF;
               end
               2'd2: begin
                  // Nine-bit arithmetic so the level saturates instead of wrapping.
                  if (dir_q == DIR_UP) begin
                     lvl9 = {1'b0, level_q} + INC9;
                     if (lvl9 >= 9'd255) begin
                        level_d = 8'hFF;
                        dir_d   = DIR_DOWN;
                     end else begin
                        level_d = lvl9[7:0];
                     end
                  end else begin
                     if ({1'b0, level_q} <= INC9) begin
                        level_d = 8'd0;
                        dir_d   = DIR_UP;
                     end else begin
                        level_d = level_q - INC9[7:0];
                     end
                  end
                  for (int i = 0; i < 8; i++) begin
                     duty_d[i] = level_d;
                  end
               end
               default: begin
                  count_d = count_q + 8'd1;
                  for (int i = 0; i < 8; i++) begin
                     duty_d[i] = {8{count_d[i]}};
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q    <= '0;
         step_cnt_q   <= '0;
         cur_mode_q   <= '0;
         pos_q        <= '0;
         dir_q        <= DIR_UP;
         level_q      <= '0;
         count_q      <= '0;
         duty_q       <= '0;
         led_q        <= '0;
         step_pulse_q <= 1'b0;
      end else begin
         pwm_cnt_q    <= pwm_cnt_d;
         step_cnt_q   <= step_cnt_d;
         cur_mode_q   <= cur_mode_d;
         pos_q        <= pos_d;
         dir_q        <= dir_d;
         level_q      <= level_d;
         count_q      <= count_d;
         duty_q       <= duty_d;
         led_q        <= led_d;
         step_pulse_q <= step_pulse_d;
      end
   end

   assign led        = led_q;
   assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_pwm.sv
// tb/tb_led_pattern_pwm.sv - directed bench for led_pattern_pwm with a behavioural pattern model
module tb_led_pattern_pwm;

   localparam int SD  = 4;
   localparam int INC = 64;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       enable = 1'b1;
   logic [1:0] mode   = 2'd3;
   logic [7:0] led;
   logic       step_pulse;

   always #5 clk = ~clk;

   led_pattern_pwm #(.STEP_DIV(SD), .BREATHE_INC(INC)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .mode       (mode),
      .led        (led),
      .step_pulse (step_pulse)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pattern state as a function of enabled-cycle count and advance index k.
   int         en_cycles;
   int         m_mode;
   int         k;
   int         m_pos;
   int         m_level;
   bit         m_up;
   int         m_duty[8];
   int         last_set[8];
   logic [7:0] m_led;
   bit         m_pulse;
   bit         mon_on = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         en_cycles = 0; m_mode = 0; k = 0; m_pos = 0; m_level = 0; m_up = 1'b1;
         for (int i = 0; i < 8; i++) begin m_duty[i] = 0; last_set[i] = -1; end
         m_led = '0; m_pulse = 1'b0;
      end else begin
         m_led = '0;
         if (enable)
            for (int i = 0; i < 8; i++) m_led[i] = (m_duty[i] > (en_cycles % 256));
         m_pulse = enable && ((en_cycles % SD) == SD - 1);
         if (m_pulse) begin
            if (int'(mode) != m_mode) begin
               m_mode = int'(mode); k = 0; m_pos = 0; m_level = 0; m_up = 1'b1;
               for (int i = 0; i < 8; i++) begin m_duty[i] = 0; last_set[i] = -1; end
            end else begin
               k++;
               case (m_mode)
                  0: for (int i = 0; i < 8; i++) m_duty[i] = 0;
                  1: begin
                     m_pos = ((k % 14) <= 7) ? (k % 14) : 14 - (k % 14);
                     last_set[m_pos] = k;
                     for (int i = 0; i < 8; i++)
                        m_duty[i] = (last_set[i] < 0 || k - last_set[i] >= 8) ? 0 : (255 >> (k - last_set[i]));
                  end
                  2: begin
                     if (m_up) begin
                        m_level = (m_level + INC > 255) ? 255 : m_level + INC;
                        if (m_level == 255) m_up = 1'b0;
                     end else begin
                        m_level = (m_level - INC < 0) ? 0 : m_level - INC;
                        if (m_level == 0) m_up = 1'b1;
                     end
                     for (int i = 0; i < 8; i++) m_duty[i] = m_level;
                  end
                  default: for (int i = 0; i < 8; i++) m_duty[i] = (((k % 256) >> i) & 1) != 0 ? 255 : 0;
               endcase
            end
         end
         if (enable) en_cycles++;
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         check("led_vs_model", int'(led), int'(m_led));
         check("step_pulse_vs_model", int'(step_pulse), int'(m_pulse));
      end
   end

   task automatic wait_pulse(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!step_pulse && n < 200);
      if (!step_pulse) begin
         checks++;
         failures++;
         $display("FAIL pulse_timeout: no step_pulse within %0d cycles at %0t", n, $time);
      end
   endtask

   int n;
   int pulses;
   int sum;
   logic [7:0] pat;
   int exp_pos[9] = '{1, 2, 3, 4, 5, 6, 7, 6, 5};
   int exp_lvl[9] = '{64, 128, 192, 255, 191, 127, 63, 0, 64};
   int en_tbl[12] = '{3, 1, 5, 2, 7, 1, 4, 6, 2, 3, 1, 9};

   initial begin
      rst = 1'b1; enable = 1'b1; mode = 2'd3;
      @(negedge clk);
      mon_on = 1'b1;
      @(negedge clk);
      check("reset_led", int'(led), 0);
      check("reset_step_pulse", int'(step_pulse), 0);
      rst = 1'b0;

      // Count mode: first tick adopts, three more advance to count=3.
      wait_pulse(n);
      check("first_pulse_gap", n, 4);
      for (int j = 0; j < 3; j++) begin
         wait_pulse(n);
         check("pulse_gap", n, 4);
      end
      for (int i = 0; i < 8; i++) pat[i] = (m_duty[i] == 255);
      check("count_pattern", int'(pat), 8'h03);
      @(negedge clk);
      check("count_led_literal", int'(led), 8'h03);
      repeat (600) @(negedge clk);

      // Scan.
      mode = 2'd1;
      wait_pulse(n);
      for (int j = 0; j < 9; j++) begin
         wait_pulse(n);
         check("scan_pos", m_pos, exp_pos[j]);
         if (j == 6) begin
            check("scan_duty7", m_duty[7], 255);
            check("scan_duty6", m_duty[6], 127);
            check("scan_duty5", m_duty[5], 63);
            check("scan_duty4", m_duty[4], 31);
         end
      end

      // Freeze mid-scan.
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("disabled_led", int'(led), 0);
      pulses = 0;
      repeat (99) begin
         @(negedge clk);
         if (step_pulse) pulses++;
      end
      check("disabled_pulses", pulses, 0);
      enable = 1'b1;
      wait_pulse(n);
      check("resume_gap", n, 3);
      check("resume_pos", m_pos, 4);

      // Switch scan -> breathe between ticks.
      @(negedge clk);
      mode = 2'd2;
      wait_pulse(n);
      sum = 0;
      for (int i = 0; i < 8; i++) sum += m_duty[i];
      check("switch_duty_zero", sum, 0);
      @(negedge clk);
      check("switch_led_off", int'(led), 0);
      for (int j = 0; j < 9; j++) begin
         wait_pulse(n);
         check("breathe_level", m_level, exp_lvl[j]);
         @(negedge clk);
         check("breathe_uniform", int'(led == 8'h00 || led == 8'hFF), 1);
      end

      // Mid-sequence reset.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_led", int'(led), 0);
      check("midrst_step_pulse", int'(step_pulse), 0);
      rst = 1'b0;
      wait_pulse(n);
      check("midrst_first_gap", n, 4);

      // Off mode.
      mode = 2'd0;
      wait_pulse(n);
      wait_pulse(n);
      repeat (3) @(negedge clk);
      check("off_led", int'(led), 0);

      // Count mode with irregular enable gating.
      mode = 2'd3;
      wait_pulse(n);
      for (int j = 0; j < 12; j++) begin
         enable = j[0];
         repeat (en_tbl[j]) @(negedge clk);
      end
      enable = 1'b1;
      repeat (300) @(negedge clk);

      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
